// File: rtl/ray_tri_sequencer.sv
// Streams every triangle of the scene past the intersection unit for one ray
// and keeps the nearest valid hit; equal t keeps the earlier index.
module ray_tri_sequencer #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_ray_valid,
    output logic              o_ray_ready,
    input  logic [191:0]      i_ray,
    input  logic [ADDR_W:0]   i_tri_count,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [287:0]      i_mem_data,
    output logic [287:0]      o_isect_tri,
    output logic [191:0]      o_isect_ray,
    input  logic              i_isect_result,
    input  logic              i_isect_overflow,
    input  logic [31:0]       i_isect_t,
    output logic              o_hit_valid,
    input  logic              i_hit_ready,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_hit_idx,
    output logic [31:0]       o_hit_t,
    output logic              o_overflow,
    output logic [1:0]        o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the offering side holds its data stable until then.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   issue;
    logic [ADDR_W-1:0] eval_idx;
    logic              eval_valid;
    logic              accept;
    logic              last_issue;
    logic              better;

    assign accept      = i_ray_valid && o_ray_ready;
    assign last_issue  = (issue == (count - ONE));
    assign o_mem_addr  = issue[ADDR_W-1:0];
    assign o_isect_tri = i_mem_data;
    assign o_dbg_state = state;

    // A fresh hit always wins; otherwise only a strictly smaller signed t.
    assign better = i_isect_result &&
                    (!o_hit || ($signed(i_isect_t) < $signed(o_hit_t)));

    always_comb begin
        state_nxt   = state;
        o_ray_ready = 1'b0;
        o_mem_rd    = 1'b0;
        o_hit_valid = 1'b0;
        case (state)
            IDLE: begin
                o_ray_ready = 1'b1;
                if (i_ray_valid) begin
                    state_nxt = (i_tri_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                o_mem_rd = 1'b1;
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                o_hit_valid = 1'b1;
                if (i_hit_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= IDLE;
            count       <= '0;
            issue       <= '0;
            eval_idx    <= '0;
            eval_valid  <= 1'b0;
            o_isect_ray <= '0;
            o_hit       <= 1'b0;
            o_hit_idx   <= '0;
            o_hit_t     <= '0;
            o_overflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            eval_valid <= (state == RUN);
            eval_idx   <= issue[ADDR_W-1:0];

            if (accept) begin
                o_isect_ray <= i_ray;
                count       <= i_tri_count;
                issue       <= '0;
                o_hit       <= 1'b0;
                o_hit_idx   <= '0;
                o_hit_t     <= '0;
                o_overflow  <= 1'b0;
            end else if (state == RUN) begin
                issue <= issue + ONE;
            end

            // Result of the triangle issued on the previous cycle.
            if (eval_valid) begin
                if (i_isect_overflow) begin
                    o_overflow <= 1'b1;
                end else if (better) begin
                    o_hit     <= 1'b1;
                    o_hit_t   <= i_isect_t;
                    o_hit_idx <= eval_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ray_tri_sequencer.sv
// Directed bench for ray_tri_sequencer: a table of rays with per-triangle
// intersection answers plus hand-written reset and full-range sequences.
module tb_ray_tri_sequencer;

    logic         i_clk = 1'b0;
    logic         i_rstn;
    logic         i_ray_valid;
    logic         o_ray_ready;
    logic [191:0] i_ray;
    logic [10:0]  i_tri_count;
    logic         o_mem_rd;
    logic [9:0]   o_mem_addr;
    logic [287:0] i_mem_data;
    logic [287:0] o_isect_tri;
    logic [191:0] o_isect_ray;
    logic         i_isect_result;
    logic         i_isect_overflow;
    logic [31:0]  i_isect_t;
    logic         o_hit_valid;
    logic         i_hit_ready;
    logic         o_hit;
    logic [9:0]   o_hit_idx;
    logic [31:0]  o_hit_t;
    logic         o_overflow;
    logic [1:0]   o_dbg_state;

    ray_tri_sequencer #(.ADDR_W(10)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_ray_valid(i_ray_valid), .o_ray_ready(o_ray_ready), .i_ray(i_ray),
        .i_tri_count(i_tri_count),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_isect_tri(o_isect_tri), .o_isect_ray(o_isect_ray),
        .i_isect_result(i_isect_result), .i_isect_overflow(i_isect_overflow),
        .i_isect_t(i_isect_t),
        .o_hit_valid(o_hit_valid), .i_hit_ready(i_hit_ready),
        .o_hit(o_hit), .o_hit_idx(o_hit_idx), .o_hit_t(o_hit_t),
        .o_overflow(o_overflow), .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [10:0]      count;
        logic [7:0]       res;
        logic [7:0]       ovf;
        logic [7:0][31:0] t;
        logic             exp_hit;
        logic [9:0]       exp_idx;
        logic [31:0]      exp_t;
        logic             exp_ovf;
    } vec_t;

    vec_t cur;
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    // Memory plus intersection unit model: answers arrive one cycle after the read.
    logic       rd_q = 1'b0;
    logic [9:0] addr_q = '0;
    always @(posedge i_clk) begin
        rd_q   <= o_mem_rd;
        addr_q <= o_mem_addr;
    end

    always_comb begin
        i_mem_data       = '0;
        i_isect_result   = 1'b0;
        i_isect_overflow = 1'b0;
        i_isect_t        = '0;
        if (rd_q) begin
            i_mem_data = {9{32'hC0DE0000 | {22'h0, addr_q}}};
            if (addr_q < 10'd8) begin
                i_isect_result   = cur.res[addr_q[2:0]];
                i_isect_overflow = cur.ovf[addr_q[2:0]];
                i_isect_t        = cur.t[addr_q[2:0]];
            end
        end
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_result(input vec_t v, input logic [191:0] ray);
        check("hit_valid", o_hit_valid, 1);
        check("hit", o_hit, v.exp_hit);
        check("hit_idx", o_hit_idx, v.exp_idx);
        check("hit_t", o_hit_t, v.exp_t);
        check("overflow", o_overflow, v.exp_ovf);
        check("isect_ray", o_isect_ray, ray);
        check("mem_rd_done", o_mem_rd, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_hit_valid", o_hit_valid, 0);
        check("rst_hit", o_hit, 0);
        check("rst_hit_idx", o_hit_idx, 0);
        check("rst_hit_t", o_hit_t, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_mem_rd", o_mem_rd, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_isect_ray", o_isect_ray, 0);
        check("rst_ray_ready", o_ray_ready, 1);
        check("rst_state", o_dbg_state, 0);
    endtask

    // Offers one ray from IDLE, follows it to DONE, then optionally handshakes.
    task automatic run_ray(input vec_t v, input int hold, input bit handshake);
        logic [191:0] ray;
        int cyc;
        int rds;
        int exp_lat;
        ray = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cur = v;
        check("ray_ready", o_ray_ready, 1);
        i_ray       = ray;
        i_tri_count = v.count;
        i_ray_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_ray_valid = 1'b0;
        i_ray       = ~ray;
        cyc = 1;
        rds = 0;
        while (!o_hit_valid && cyc < 3000) begin
            if (o_mem_rd) begin
                if (o_mem_addr !== 10'(rds)) check("mem_addr", o_mem_addr, 10'(rds));
                rds++;
            end
            if (rd_q && o_isect_tri !== i_mem_data) check("isect_tri", o_isect_tri, i_mem_data);
            @(posedge i_clk);
            #1;
            cyc++;
        end
        exp_lat = (v.count == 0) ? 1 : int'(v.count) + 2;
        check("latency", 192'(cyc), 192'(exp_lat));
        check("mem_rd_count", 192'(rds), 192'(v.count));
        check_result(v, ray);
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk);
            #1;
            check_result(v, ray);
        end
        if (handshake) begin
            i_hit_ready = 1'b1;
            @(posedge i_clk);
            #1;
            i_hit_ready = 1'b0;
            check("hs_hit_valid", o_hit_valid, 0);
            check("hs_ray_ready", o_ray_ready, 1);
            check("hs_isect_ray", o_isect_ray, ray);
        end
    endtask

    initial begin
        vec_t v;
        int   hv;
        int   rdn;

        // Table of rays; t entries for non-hitting triangles are decoys.
        v = '{default: 0}; v.count = 4; v.res = 8'b0000_0100;
        v.t[0] = 1; v.t[1] = 1; v.t[2] = 32'h00030000; v.t[3] = 1;
        v.exp_hit = 1; v.exp_idx = 2; v.exp_t = 32'h00030000; vecs[0] = v;

        v = '{default: 0}; v.count = 3; v.res = 8'b0000_0111;
        v.t[0] = 5; v.t[1] = 2; v.t[2] = 2;
        v.exp_hit = 1; v.exp_idx = 1; v.exp_t = 2; vecs[1] = v;

        v = '{default: 0}; v.count = 0; v.res = 8'hFF; v.t[0] = 7;
        vecs[2] = v;

        v = '{default: 0}; v.count = 2; v.res = 8'b0000_0001; v.ovf = 8'b0000_0001;
        v.t[0] = 1; v.exp_ovf = 1; vecs[3] = v;

        v = '{default: 0}; v.count = 5; v.res = 8'b0001_0110;
        v.t[1] = 3; v.t[2] = 32'hFFFFFFF9; v.t[4] = 32'hFFFFFFFE;
        v.exp_hit = 1; v.exp_idx = 2; v.exp_t = 32'hFFFFFFF9; vecs[4] = v;

        v = '{default: 0}; v.count = 3; v.res = 8'b0000_0111; v.ovf = 8'b0000_0010;
        v.t[0] = 8; v.t[1] = 1; v.t[2] = 4;
        v.exp_hit = 1; v.exp_idx = 2; v.exp_t = 4; v.exp_ovf = 1; vecs[5] = v;

        v = '{default: 0}; v.count = 3; v.res = 8'b0000_0100;
        v.t[0] = 32'h80000000; v.t[2] = 0;
        v.exp_hit = 1; v.exp_idx = 2; v.exp_t = 0; vecs[6] = v;

        v = '{default: 0}; v.count = 8; v.res = 8'b1000_0001;
        v.t[0] = 200; v.t[7] = 100;
        v.exp_hit = 1; v.exp_idx = 7; v.exp_t = 100; vecs[7] = v;

        cur         = '{default: 0};
        i_rstn      = 1'b0;
        i_ray_valid = 1'b0;
        i_ray       = '0;
        i_tri_count = '0;
        i_hit_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs();
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        // Back-to-back rays; ray 1 waits 5 cycles on the downstream.
        for (int i = 0; i < 8; i++) begin
            run_ray(vecs[i], (i == 1) ? 5 : 0, 1'b1);
        end

        // Whole address range, no hits anywhere.
        v = '{default: 0}; v.count = 11'd1024;
        run_ray(v, 0, 1'b1);

        // Reset while the result is being offered.
        run_ray(vecs[0], 2, 1'b0);
        i_rstn = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        check_reset_outputs();

        // Reset part-way through a scan: nothing may be reported afterwards.
        cur         = vecs[7];
        i_ray       = {6{32'h12345678}};
        i_tri_count = 11'd8;
        i_ray_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_ray_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("midrun_mem_rd", o_mem_rd, 1);
        i_rstn = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        hv  = 0;
        rdn = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_hit_valid) hv++;
            if (o_mem_rd) rdn++;
            @(posedge i_clk);
            #1;
        end
        check("abort_hit_valid", 192'(hv), 0);
        check("abort_mem_rd", 192'(rdn), 0);
        check("abort_hit", o_hit, 0);

        run_ray(vecs[1], 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ray_tri_sequencer.md
Name: ray_tri_sequencer

Overview:
- Feeds the ray-triangle intersection unit: accepts one ray, streams every triangle of the scene from triangle memory through the intersection unit, and reports the nearest hit.
- Drives the intersection unit's triangle and ray inputs; consumes its result, overflow and t outputs.
- Sits between the ray generator (upstream, valid/ready) and the shader (downstream, valid/ready).
- All vectors are 32-bit signed fixed-point.

Parameters:
- ADDR_W, 10, triangle memory address width; up to 2^ADDR_W triangles.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_ray_valid  in  1  ray offered
- o_ray_ready  out  1  ray accepted when high with i_ray_valid
- i_ray  in  192  packed [1] origin, [0] direction, each 3x32 signed
- i_tri_count  in  ADDR_W+1  number of triangles; sampled on ray accept
- o_mem_rd  out  1  triangle memory read strobe
- o_mem_addr  out  ADDR_W  triangle index
- i_mem_data  in  288  triangle, 3 corners x 3x32; valid exactly 1 cycle after o_mem_rd
- o_isect_tri  out  288  to intersection unit; combinational pass-through of i_mem_data
- o_isect_ray  out  192  registered ray captured at accept
- i_isect_result  in  1  intersection unit hit flag
- i_isect_overflow  in  1  intersection unit overflow flag
- i_isect_t  in  32  intersection unit signed t
- o_hit_valid  out  1  result available
- i_hit_ready  in  1  downstream accepts result
- o_hit  out  1  1 if any valid hit
- o_hit_idx  out  ADDR_W  index of nearest hit
- o_hit_t  out  32  t of nearest hit
- o_overflow  out  1  sticky: at least one triangle reported overflow for this ray

Behaviour:
- Reset (i_rstn=0 at a rising edge): state IDLE. o_mem_rd=0, o_mem_addr=0, o_hit_valid=0, o_hit=0, o_hit_idx=0, o_hit_t=0, o_overflow=0, o_isect_ray=0, internal counters=0.
- Reset mid-operation aborts the current ray with no result emitted.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - o_ray_ready=1.
  - On i_ray_valid & o_ray_ready: latch i_ray into o_isect_ray; latch i_tri_count; clear best (o_hit=0, o_overflow=0, o_hit_t=0, o_hit_idx=0).
  - Count=0: go to DONE. Otherwise go to RUN with issue address=0.
- RUN:
  - o_ray_ready=0. o_mem_rd=1, o_mem_addr=issue address.
  - Issue address increments each cycle.
  - On the cycle the last index (count-1) is issued, go to DRAIN next.
- Evaluation:
  - A delayed valid bit marks the cycle after each issue; i_mem_data and i_isect_* then belong to index issue-1.
  - That cycle, if i_isect_overflow=1: set o_overflow; the triangle is a miss.
  - Else if i_isect_result=1 and (o_hit=0 or signed i_isect_t < o_hit_t): update o_hit=1, o_hit_t=i_isect_t, o_hit_idx=evaluated index.
  - Equal t keeps the earlier (lower) index.
- DRAIN: o_mem_rd=0; evaluate the last triangle; go to DONE.
- DONE:
  - o_hit_valid=1; outputs held stable until i_hit_ready=1.
  - On the handshake, go to IDLE; o_hit_valid=0 next cycle.
- Latency:
  - Accept at edge k, count N>0: o_hit_valid high in cycle k+N+2.
  - N=0: o_hit_valid high in cycle k+1.
  - Throughput is one triangle per cycle; a new ray is accepted one cycle after the DONE handshake.
- i_tri_count = 2^ADDR_W: the full address range is issued; the issue counter is ADDR_W+1 bits, so no wrap-around occurs.
- o_isect_ray is stable from the accept until the next accept.
- o_mem_rd is never high outside RUN.

Test Plan:
- Reset with o_hit_valid=1 in DONE -> all outputs 0 on the next cycle; o_ray_ready=1.
- Count=4, hits only at index 2 with t=0x00030000 -> o_hit_valid at k+6, o_hit=1, o_hit_idx=2, o_hit_t=0x00030000, o_overflow=0.
- Count=3, hits at idx0 t=5, idx1 t=2, idx2 t=2 -> o_hit_idx=1, o_hit_t=2 (tie keeps lower index).
- Count=0 -> o_hit_valid at k+1, o_hit=0, o_mem_rd never asserted.
- Count=2, idx0 overflow=1 with result=1 t=1, idx1 miss -> o_hit=0, o_overflow=1.
- i_hit_ready low for 5 cycles in DONE, then high -> outputs unchanged throughout; next ray accepted one cycle after the handshake; the second ray's outputs are not polluted by the first.
